ysyx_22050019_mem_arb: RTL and testbench

- Two-requester arbiter sharing the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time and latches it. Drives it onto the memory port, then routes the memory response back to the requester that owns it.
- Only one transaction is outstanding at a time. A timeout guards against a hung memory.
- Sits between the IFU/LSU and the memory bridge. The LSU side carries the ram_we/ram_re/width information that the decode stage produces.

---
 rtl/ysyx_22050019_mem_arb.sv | 201 ++++++++++++++++++++
 tb/tb_ysyx_22050019_mem_arb.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050019_mem_arb.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_mem_arb
//
// Shares the core's single memory port between the instruction fetch unit
// (IFU) and the load/store unit (LSU). One request is accepted at a time and
// latched. It is then driven onto the memory port, and the memory response is
// routed back to the requester that owns it. A cycle counter reports a
// timeout error to the owner if memory never answers.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ifu_req_*         IFU read request (valid/ready handshake, address)
//   ifu_rsp_*         IFU response pulse: data, timeout error flag
//   lsu_req_*         LSU request: address, we, store data, byte mask
//   lsu_rsp_*         LSU response pulse: load data / store ack, error flag
//   mem_req_*         request to memory (valid/ready), latched fields
//   mem_rsp_*         memory response (valid, read data)
// ---------------------------------------------------------------------------
module ysyx_22050019_mem_arb #(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int LSU_PRIO = 1,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   output logic [DATA_W-1:0]   ifu_rsp_data,
   output logic                ifu_rsp_err,

   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_we,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_rsp_valid,
   output logic [DATA_W-1:0]   lsu_rsp_data,
   output logic                lsu_rsp_err,

   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_data
);

   localparam int MASK_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   // The TIMEOUT-th cycle spent in ISSUE+WAIT is the one where the counter
   // (cleared on accept) still reads TIMEOUT-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                owner;        // 0 = IFU, 1 = LSU
   logic                last_grant;   // 0 = IFU, 1 = LSU
   logic [ADDR_W-1:0]   lat_addr;
   logic                lat_we;
   logic [DATA_W-1:0]   lat_wdata;
   logic [MASK_W-1:0]   lat_wmask;
   logic [CNT_W-1:0]    cnt;

   logic                pick_lsu;
   logic                pick_ifu;
   logic                timeout_hit;
   logic                rsp_fire;
   logic                rsp_err;
   logic [DATA_W-1:0]   rsp_data;

   // LSU wins a tie under fixed priority, or under round-robin when the IFU
   // had the previous grant. A lone requester always wins.
   assign pick_lsu    = lsu_req_valid &&
                        (!ifu_req_valid || (LSU_PRIO != 0) || !last_grant);
   assign pick_ifu    = ifu_req_valid && !pick_lsu;
   assign timeout_hit = (TIMEOUT != 0) && (state != IDLE) && (cnt == CNT_LAST);

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b0;
         lat_addr   <= '0;
         lat_we     <= 1'b0;
         lat_wdata  <= '0;
         lat_wmask  <= '0;
         cnt        <= '0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && (pick_lsu || pick_ifu)) begin
            owner      <= pick_lsu;
            last_grant <= pick_lsu;
            cnt        <= '0;
            if (pick_lsu) begin
               lat_addr  <= lsu_addr;
               lat_we    <= lsu_we;
               lat_wdata <= lsu_wdata;
               lat_wmask <= lsu_wmask;
            end else begin
               // Fetches are always plain reads.
               lat_addr  <= ifu_addr;
               lat_we    <= 1'b0;
               lat_wdata <= '0;
               lat_wmask <= '0;
            end
         end else if (state != IDLE) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt     = state;
      rsp_fire      = 1'b0;
      rsp_err       = 1'b0;
      rsp_data      = '0;
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      mem_req_valid = 1'b0;
      mem_addr      = lat_addr;
      mem_we        = lat_we;
      mem_wdata     = lat_wdata;
      mem_wmask     = lat_wmask;

      case (state)
         IDLE: begin
            ifu_req_ready = pick_ifu;
            lsu_req_ready = pick_lsu;
            if (pick_ifu || pick_lsu) state_nxt = ISSUE;
         end
         ISSUE: begin
            // Drop the request on timeout so memory cannot accept a
            // transaction nobody is waiting for any more.
            mem_req_valid = !timeout_hit;
            if (timeout_hit) begin
               rsp_fire  = 1'b1;
               rsp_err   = 1'b1;
               state_nxt = IDLE;
            end else if (mem_req_ready) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // A response arriving on the timeout cycle still wins.
            if (mem_rsp_valid) begin
               rsp_fire  = 1'b1;
               rsp_data  = mem_rsp_data;
               state_nxt = IDLE;
            end else if (timeout_hit) begin
               rsp_fire  = 1'b1;
               rsp_err   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      ifu_rsp_valid = rsp_fire && !owner;
      ifu_rsp_err   = rsp_err  && !owner;
      ifu_rsp_data  = owner ? '0 : rsp_data;
      lsu_rsp_valid = rsp_fire && owner;
      lsu_rsp_err   = rsp_err  && owner;
      lsu_rsp_data  = owner ? rsp_data : '0;

      // Outputs are forced quiet while reset is asserted, so an abandoned
      // transaction can never emit a response in the reset cycle.
      if (rst) begin
         ifu_req_ready = 1'b0;
         lsu_req_ready = 1'b0;
         ifu_rsp_valid = 1'b0;
         ifu_rsp_err   = 1'b0;
         ifu_rsp_data  = '0;
         lsu_rsp_valid = 1'b0;
         lsu_rsp_err   = 1'b0;
         lsu_rsp_data  = '0;
         mem_req_valid = 1'b0;
         mem_addr      = '0;
         mem_we        = 1'b0;
         mem_wdata     = '0;
         mem_wmask     = '0;
      end
   end

endmodule

// File: tb/tb_ysyx_22050019_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050019_mem_arb
//
// Two arbiters share one set of stimulus: instance 0 uses fixed LSU priority,
// instance 1 round-robin, both with an 8-cycle timeout. The one not under
// test is held in reset, and sel picks whose outputs are observed. Expected
// responses go into a queue when a grant is made; a monitor pops and compares
// them whenever a response pulse appears.
// ---------------------------------------------------------------------------
module tb_ysyx_22050019_mem_arb;

   localparam int TB_TIMEOUT = 8;

   typedef struct packed {
      logic        lsu;
      logic [63:0] data;
      logic        err;
   } rsp_t;

   logic        clk;
   logic        rst_v [2];
   logic        sel;

   logic        ifu_req_valid;
   logic [63:0] ifu_addr;
   logic        lsu_req_valid;
   logic [63:0] lsu_addr;
   logic        lsu_we;
   logic [63:0] lsu_wdata;
   logic [7:0]  lsu_wmask;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_data;

   logic        ifu_req_ready_v [2];
   logic        ifu_rsp_valid_v [2];
   logic [63:0] ifu_rsp_data_v  [2];
   logic        ifu_rsp_err_v   [2];
   logic        lsu_req_ready_v [2];
   logic        lsu_rsp_valid_v [2];
   logic [63:0] lsu_rsp_data_v  [2];
   logic        lsu_rsp_err_v   [2];
   logic        mem_req_valid_v [2];
   logic [63:0] mem_addr_v      [2];
   logic        mem_we_v        [2];
   logic [63:0] mem_wdata_v     [2];
   logic [7:0]  mem_wmask_v     [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ysyx_22050019_mem_arb #(
         .ADDR_W  (64),
         .DATA_W  (64),
         .LSU_PRIO((g == 0) ? 1 : 0),
         .TIMEOUT (TB_TIMEOUT)
      ) dut (
         .clk          (clk),
         .rst          (rst_v[g]),
         .ifu_req_valid(ifu_req_valid),
         .ifu_req_ready(ifu_req_ready_v[g]),
         .ifu_addr     (ifu_addr),
         .ifu_rsp_valid(ifu_rsp_valid_v[g]),
         .ifu_rsp_data (ifu_rsp_data_v[g]),
         .ifu_rsp_err  (ifu_rsp_err_v[g]),
         .lsu_req_valid(lsu_req_valid),
         .lsu_req_ready(lsu_req_ready_v[g]),
         .lsu_addr     (lsu_addr),
         .lsu_we       (lsu_we),
         .lsu_wdata    (lsu_wdata),
         .lsu_wmask    (lsu_wmask),
         .lsu_rsp_valid(lsu_rsp_valid_v[g]),
         .lsu_rsp_data (lsu_rsp_data_v[g]),
         .lsu_rsp_err  (lsu_rsp_err_v[g]),
         .mem_req_valid(mem_req_valid_v[g]),
         .mem_req_ready(mem_req_ready),
         .mem_addr     (mem_addr_v[g]),
         .mem_we       (mem_we_v[g]),
         .mem_wdata    (mem_wdata_v[g]),
         .mem_wmask    (mem_wmask_v[g]),
         .mem_rsp_valid(mem_rsp_valid),
         .mem_rsp_data (mem_rsp_data)
      );
   end

   logic        o_ifu_req_ready, o_ifu_rsp_valid, o_ifu_rsp_err;
   logic        o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rsp_err;
   logic        o_mem_req_valid, o_mem_we;
   logic [63:0] o_ifu_rsp_data, o_lsu_rsp_data, o_mem_addr, o_mem_wdata;
   logic [7:0]  o_mem_wmask;

   assign o_ifu_req_ready = ifu_req_ready_v[sel];
   assign o_ifu_rsp_valid = ifu_rsp_valid_v[sel];
   assign o_ifu_rsp_data  = ifu_rsp_data_v[sel];
   assign o_ifu_rsp_err   = ifu_rsp_err_v[sel];
   assign o_lsu_req_ready = lsu_req_ready_v[sel];
   assign o_lsu_rsp_valid = lsu_rsp_valid_v[sel];
   assign o_lsu_rsp_data  = lsu_rsp_data_v[sel];
   assign o_lsu_rsp_err   = lsu_rsp_err_v[sel];
   assign o_mem_req_valid = mem_req_valid_v[sel];
   assign o_mem_addr      = mem_addr_v[sel];
   assign o_mem_we        = mem_we_v[sel];
   assign o_mem_wdata     = mem_wdata_v[sel];
   assign o_mem_wmask     = mem_wmask_v[sel];

   int   checks   = 0;
   int   failures = 0;
   rsp_t exp_q [$];
   rsp_t mon_e;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Response monitor: samples well after inputs change at the falling edge.
   always @(negedge clk) begin
      #2;
      if (o_ifu_rsp_valid || o_lsu_rsp_valid) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", {o_ifu_rsp_valid, o_lsu_rsp_valid}, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_owner", {o_ifu_rsp_valid, o_lsu_rsp_valid}, mon_e.lsu ? 2'b01 : 2'b10);
            check("rsp_data", mon_e.lsu ? o_lsu_rsp_data : o_ifu_rsp_data, mon_e.data);
            check("rsp_err", mon_e.lsu ? o_lsu_rsp_err : o_ifu_rsp_err, mon_e.err);
         end
      end
   end

   // Called right after inputs are set at a falling edge: checks who is
   // granted and queues the response that grant must eventually produce.
   task automatic grant(input string tag, input logic exp_lsu,
                        input logic [63:0] rdata, input logic err);
      #1;
      check({tag, "_grant"}, {o_ifu_req_ready, o_lsu_req_ready}, exp_lsu ? 2'b01 : 2'b10);
      exp_q.push_back('{lsu: exp_lsu, data: rdata, err: err});
   endtask

   // Plays memory for the transaction accepted at the preceding rising edge.
   // Cycle k counts from 1 (first ISSUE cycle). ready_at=0: memory never
   // accepts; rsp_at=0: memory never responds (timeout at k=TB_TIMEOUT).
   // Returns at the falling edge of the first cycle back in IDLE.
   task automatic serve(input string tag, input logic owner_lsu, input logic drop,
                        input int ready_at, input int rsp_at, input logic [63:0] rdata,
                        input logic [63:0] e_addr, input logic e_we,
                        input logic [63:0] e_wdata, input logic [7:0] e_wmask,
                        input logic late_ifu);
      int   last;
      logic mreq_exp;
      last = (rsp_at > 0) ? rsp_at : TB_TIMEOUT;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         if (k == 1 && drop) begin
            if (owner_lsu) lsu_req_valid = 1'b0;
            else           ifu_req_valid = 1'b0;
         end
         if (late_ifu && k == 2) begin
            ifu_req_valid = 1'b1;
            ifu_addr      = 64'h8000_0100;
         end
         mem_req_ready = (k == ready_at);
         mem_rsp_valid = (k == rsp_at);
         mem_rsp_data  = (k == rsp_at) ? rdata : 64'h0;
         #1;
         mreq_exp = (ready_at == 0 || k <= ready_at) && !(rsp_at == 0 && k == last);
         check({tag, "_mreq_valid"}, o_mem_req_valid, mreq_exp);
         if (mreq_exp) begin
            check({tag, "_maddr"}, o_mem_addr, e_addr);
            check({tag, "_mwe"}, o_mem_we, e_we);
            check({tag, "_mwdata"}, o_mem_wdata, e_wdata);
            check({tag, "_mwmask"}, o_mem_wmask, e_wmask);
         end
         check({tag, "_busy_ready"}, {o_ifu_req_ready, o_lsu_req_ready}, 0);
      end
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 64'h0;
   endtask

   initial begin
      sel           = 1'b0;
      rst_v[0]      = 1'b1;
      rst_v[1]      = 1'b1;
      ifu_req_valid = 1'b1;
      ifu_addr      = 64'h8000_0000;
      lsu_req_valid = 1'b1;
      lsu_addr      = 64'h8000_1000;
      lsu_we        = 1'b1;
      lsu_wdata     = 64'h1;
      lsu_wmask     = 8'hFF;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h5A5A;

      // Reset with every input active: all outputs must stay quiet.
      repeat (2) @(negedge clk);
      #1;
      check("rst_ctrl", {o_ifu_req_ready, o_lsu_req_ready, o_ifu_rsp_valid,
                         o_lsu_rsp_valid, o_mem_req_valid, o_mem_we}, 0);
      check("rst_maddr", o_mem_addr, 0);

      @(negedge clk);
      rst_v[0]      = 1'b0;
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      lsu_we        = 1'b0;
      lsu_wdata     = 64'h0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 64'h0;
      #1;
      check("post_rst_ctrl", {o_ifu_req_ready, o_lsu_req_ready, o_mem_req_valid}, 0);

      // Single IFU fetch.
      @(negedge clk);
      ifu_req_valid = 1'b1;
      ifu_addr      = 64'h8000_0000;
      grant("fetch", 1'b0, 64'h0000_0413, 1'b0);
      serve("fetch", 1'b0, 1'b1, 1, 3, 64'h0000_0413, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 1'b0);

      // Simultaneous requests under fixed priority: LSU store first.
      ifu_req_valid = 1'b1;
      ifu_addr      = 64'h8000_0004;
      lsu_req_valid = 1'b1;
      lsu_addr      = 64'h8000_1000;
      lsu_we        = 1'b1;
      lsu_wdata     = 64'hDEAD_BEEF;
      lsu_wmask     = 8'h0F;
      grant("prio_lsu", 1'b1, 64'h1234, 1'b0);
      serve("prio_lsu", 1'b1, 1'b1, 1, 3, 64'h1234, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b0);
      grant("prio_ifu", 1'b0, 64'h0000_0013, 1'b0);
      serve("prio_ifu", 1'b0, 1'b1, 1, 3, 64'h0000_0013, 64'h8000_0004, 1'b0, 64'h0, 8'h00, 1'b0);

      // Backpressure: memory not ready for 5 cycles, late IFU request held off.
      lsu_req_valid = 1'b1;
      lsu_addr      = 64'h8000_2000;
      lsu_we        = 1'b0;
      lsu_wdata     = 64'h0;
      lsu_wmask     = 8'hFF;
      grant("bp", 1'b1, 64'hCAFE, 1'b0);
      serve("bp", 1'b1, 1'b1, 6, 7, 64'hCAFE, 64'h8000_2000, 1'b0, 64'h0, 8'hFF, 1'b1);
      grant("bp_ifu", 1'b0, 64'h77, 1'b0);
      serve("bp_ifu", 1'b0, 1'b1, 1, 3, 64'h77, 64'h8000_0100, 1'b0, 64'h0, 8'h00, 1'b0);

      // Timeout in WAIT, then a stray response that must be ignored.
      lsu_req_valid = 1'b1;
      lsu_addr      = 64'h8000_3000;
      grant("to_wait", 1'b1, 64'h0, 1'b1);
      serve("to_wait", 1'b1, 1'b1, 1, 0, 64'h0, 64'h8000_3000, 1'b0, 64'h0, 8'hFF, 1'b0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'hBAD;
      #1;
      check("stray_rsp", {o_ifu_rsp_valid, o_lsu_rsp_valid, o_mem_req_valid}, 0);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 64'h0;

      // Response on the timeout cycle is a normal response.
      ifu_req_valid = 1'b1;
      ifu_addr      = 64'h8000_0040;
      grant("to_edge", 1'b0, 64'h99, 1'b0);
      serve("to_edge", 1'b0, 1'b1, 1, TB_TIMEOUT, 64'h99, 64'h8000_0040, 1'b0, 64'h0, 8'h00, 1'b0);

      // Timeout while still stuck in ISSUE.
      ifu_req_valid = 1'b1;
      ifu_addr      = 64'h8000_0080;
      grant("to_issue", 1'b0, 64'h0, 1'b1);
      serve("to_issue", 1'b0, 1'b1, 0, 0, 64'h0, 64'h8000_0080, 1'b0, 64'h0, 8'h00, 1'b0);

      // Switch to the round-robin instance.
      rst_v[0] = 1'b1;
      rst_v[1] = 1'b0;
      sel      = 1'b1;
      @(negedge clk);
      ifu_req_valid = 1'b1;
      ifu_addr      = 64'h8000_0200;
      lsu_req_valid = 1'b1;
      lsu_addr      = 64'h8000_4000;
      lsu_we        = 1'b0;
      lsu_wmask     = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         logic l;
         l = (i % 2 == 0);
         grant("rr", l, 64'h100 + 64'(i), 1'b0);
         serve("rr", l, 1'b0, 1, 3, 64'h100 + 64'(i), l ? 64'h8000_4000 : 64'h8000_0200,
               1'b0, 64'h0, l ? 8'hFF : 8'h00, 1'b0);
      end

      // Lone LSU accepted (last_grant=LSU), reset while in WAIT.
      ifu_req_valid = 1'b0;
      #1;
      check("rstw_acc", {o_ifu_req_ready, o_lsu_req_ready}, 2'b01);
      @(negedge clk);
      lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst_v[1]      = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'hBAD1;
      #1;
      check("rstw_rsp", {o_ifu_rsp_valid, o_lsu_rsp_valid}, 0);
      @(negedge clk);
      rst_v[1] = 1'b0;
      #1;
      check("rstw_stray", {o_ifu_rsp_valid, o_lsu_rsp_valid, o_mem_req_valid}, 0);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 64'h0;
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      grant("rstw_tie", 1'b1, 64'h555, 1'b0);
      serve("rstw_tie", 1'b1, 1'b1, 1, 3, 64'h555, 64'h8000_4000, 1'b0, 64'h0, 8'hFF, 1'b0);
      grant("rstw_ifu", 1'b0, 64'h666, 1'b0);
      serve("rstw_ifu", 1'b0, 1'b1, 1, 3, 64'h666, 64'h8000_0200, 1'b0, 64'h0, 8'h00, 1'b0);

      @(negedge clk);
      #3;
      check("pending_rsp", 64'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
